// File: rtl/audio_pkg.sv
// Shared constants and state encoding for the stereo audio sample buffer.
package audio_pkg;

    localparam int unsigned AUD_BIT_DEPTH_DEF = 24;
    localparam int unsigned UNDERRUN_CNT_W    = 16;

    typedef enum logic {
        S_PRIME = 1'b0,
        S_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous FIFO for stereo pairs, with an explicit occupancy counter.
// Pushes are ignored when full and pops are ignored when empty.
module audio_sample_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      fill
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (fill != (AW+1)'(DEPTH));
    assign do_pop  = pop && (fill != '0);
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally; fill tracks occupancy independently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/audio_sample_buffer.sv
// Stereo elastic buffer: engine pushes L/R pairs, one pair popped per LRCK frame.
// Define AUDIO_UNDERRUN_CNT_EN to enable the saturating underrun counter.
module audio_sample_buffer
    import audio_pkg::*;
#(
    parameter int unsigned AUD_BIT_DEPTH = AUD_BIT_DEPTH_DEF,
    parameter int unsigned FIFO_AW       = 2,
    parameter int unsigned PRIME_LEVEL   = 2
) (
    input  logic                      iCLK,
    input  logic                      reset,
    input  logic                      iAUD_DACLRCK,
    input  logic                      i_sample_valid,
    output logic                      o_sample_ready,
    input  logic [AUD_BIT_DEPTH-1:0]  i_lsample,
    input  logic [AUD_BIT_DEPTH-1:0]  i_rsample,
    output logic [AUD_BIT_DEPTH-1:0]  o_lsound_out,
    output logic [AUD_BIT_DEPTH-1:0]  o_rsound_out,
    output logic                      o_frame_tick,
    output logic                      o_underrun,
    output logic [FIFO_AW:0]          o_fill,
    output logic [UNDERRUN_CNT_W-1:0] o_underrun_cnt
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned PAIR_W = 2 * AUD_BIT_DEPTH;

    state_t              state;
    logic                lrck_s1;
    logic                lrck_s2;
    logic                lrck_dly;
    logic                boundary;
    logic                push;
    logic                pop;
    logic [FIFO_AW:0]    fill;
    logic [PAIR_W-1:0]   head;

    // Two-stage synchroniser plus one delay stage for falling-edge detection.
    always_ff @(posedge iCLK or posedge reset) begin
        if (reset) begin
            lrck_s1  <= 1'b0;
            lrck_s2  <= 1'b0;
            lrck_dly <= 1'b0;
        end else begin
            lrck_s1  <= iAUD_DACLRCK;
            lrck_s2  <= lrck_s1;
            lrck_dly <= lrck_s2;
        end
    end

    assign boundary       = lrck_dly & ~lrck_s2;
    assign o_sample_ready = (fill != (FIFO_AW+1)'(DEPTH));
    assign push           = i_sample_valid & o_sample_ready;
    assign o_fill         = fill;

    // Pops see only the registered fill, so a same-cycle push never bypasses.
    always_comb begin
        pop = 1'b0;
        if (boundary) begin
            if (state == S_PRIME) pop = (fill >= (FIFO_AW+1)'(PRIME_LEVEL));
            else                  pop = (fill != '0);
        end
    end

    audio_sample_fifo #(
        .WIDTH (PAIR_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (iCLK),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({i_lsample, i_rsample}),
        .rdata (head),
        .fill  (fill)
    );

    // Prime/run control with held output pair, tick and underrun pulses.
    always_ff @(posedge iCLK or posedge reset) begin
        if (reset) begin
            state        <= S_PRIME;
            o_lsound_out <= '0;
            o_rsound_out <= '0;
            o_frame_tick <= 1'b0;
            o_underrun   <= 1'b0;
        end else begin
            o_frame_tick <= boundary;
            o_underrun   <= boundary && (state == S_RUN) && (fill == '0);
            if (pop) begin
                o_lsound_out <= head[PAIR_W-1:AUD_BIT_DEPTH];
                o_rsound_out <= head[AUD_BIT_DEPTH-1:0];
            end
            if (boundary) begin
                case (state)
                    S_PRIME: if (pop)          state <= S_RUN;
                    S_RUN:   if (fill == '0)   state <= S_PRIME;
                    default:                   state <= S_PRIME;
                endcase
            end
        end
    end

`ifdef AUDIO_UNDERRUN_CNT_EN
    logic [UNDERRUN_CNT_W-1:0] underrun_cnt;

    always_ff @(posedge iCLK or posedge reset) begin
        if (reset) begin
            underrun_cnt <= '0;
        end else if (o_underrun && (underrun_cnt != '1)) begin
            underrun_cnt <= underrun_cnt + 1'b1;
        end
    end

    assign o_underrun_cnt = underrun_cnt;
`else
    assign o_underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_audio_sample_buffer.sv
// Bench for audio_sample_buffer: directed frame scenarios plus randomized traffic
// checked every cycle against a queue-based model of the buffer.
module tb_audio_sample_buffer;

    localparam int unsigned W     = 24;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PRIME = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lrck = 1'b0;
    logic          valid = 1'b0;
    logic [W-1:0]  lsample = '0;
    logic [W-1:0]  rsample = '0;
    logic          ready;
    logic [W-1:0]  lout;
    logic [W-1:0]  rout;
    logic          tick;
    logic          underrun;
    logic [2:0]    fill;
    logic [15:0]   ucnt;

    int checks = 0;
    int errors = 0;

    audio_sample_buffer dut (
        .iCLK           (clk),
        .reset          (rst),
        .iAUD_DACLRCK   (lrck),
        .i_sample_valid (valid),
        .o_sample_ready (ready),
        .i_lsample      (lsample),
        .i_rsample      (rsample),
        .o_lsound_out   (lout),
        .o_rsound_out   (rout),
        .o_frame_tick   (tick),
        .o_underrun     (underrun),
        .o_fill         (fill),
        .o_underrun_cnt (ucnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO as a queue; a frame boundary is judged from pin samples three
    // and two edges back (pin high then low), producing tick on the following edge.
    logic [2*W-1:0] q[$];
    logic [W-1:0]   m_l = '0;
    logic [W-1:0]   m_r = '0;
    logic           m_tick = 1'b0;
    logic           m_und = 1'b0;
    logic           m_run = 1'b0;
    logic [15:0]    m_cnt = '0;
    logic           h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

    always @(posedge clk) begin
        int  n;
        bit  bnd;
        bit  do_push;
        bit  do_pop;
        if (rst) begin
            q.delete();
            m_l = '0; m_r = '0; m_tick = 1'b0; m_und = 1'b0; m_run = 1'b0;
            m_cnt = '0; h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        end else begin
            n       = q.size();
            bnd     = h3 && !h2;
            do_push = valid && (n < DEPTH);
            do_pop  = bnd && (m_run ? (n > 0) : (n >= PRIME));
            m_tick  = bnd;
            m_und   = bnd && m_run && (n == 0);
            if (do_pop) {m_l, m_r} = q.pop_front();
            if (do_push) q.push_back({lsample, rsample});
            if (bnd) m_run = m_run ? (n != 0) : do_pop;
`ifdef AUDIO_UNDERRUN_CNT_EN
            if (m_und && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
            h3 = h2; h2 = h1; h1 = lrck;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("fill",     64'(fill),     64'(q.size()));
            check("ready",    64'(ready),    64'(q.size() < DEPTH));
            check("lout",     64'(lout),     64'(m_l));
            check("rout",     64'(rout),     64'(m_r));
            check("tick",     64'(tick),     64'(m_tick));
            check("underrun", 64'(underrun), 64'(m_und));
            check("ucnt",     64'(ucnt),     64'(m_cnt));
        end
    end

    // All stimulus tasks begin and end at a falling clock edge.
    task automatic push_pair(input logic [W-1:0] l, input logic [W-1:0] r);
        valid = 1'b1; lsample = l; rsample = r;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_tick(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (tick) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_tick_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic boundary(input string name);
        lrck = 1'b1;
        repeat (2) @(negedge clk);
        lrck = 1'b0;
        wait_tick(name);
    endtask

    initial begin
        int ticks;
        int half;
        int pct;

        repeat (2) @(negedge clk);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_fill",  64'(fill),  64'd0);
        check("rst_lout",  64'(lout),  64'd0);
        check("rst_tick",  64'(tick),  64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Prime with two pairs, then two frames drain them.
        push_pair(24'h000001, 24'h000002);
        push_pair(24'h000003, 24'h000004);
        boundary("t1a");
        check("t1a_l", 64'(lout), 64'h1);
        check("t1a_r", 64'(rout), 64'h2);
        boundary("t1b");
        check("t1b_l", 64'(lout), 64'h3);
        check("t1b_r", 64'(rout), 64'h4);
        check("t1b_fill", 64'(fill), 64'd0);

        // Empty while running: underrun, outputs hold.
        boundary("t3");
        check("t3_und", 64'(underrun), 64'd1);
        check("t3_l", 64'(lout), 64'h3);
        check("t3_r", 64'(rout), 64'h4);
`ifdef AUDIO_UNDERRUN_CNT_EN
        @(negedge clk);
        check("t3_cnt", 64'(ucnt), 64'd1);
`else
        @(negedge clk);
        check("t3_cnt", 64'(ucnt), 64'd0);
`endif
        check("t3_und_low", 64'(underrun), 64'd0);

        // Priming again: one pair is not enough, two are.
        push_pair(24'h000005, 24'h000006);
        boundary("t4a");
        check("t4a_l", 64'(lout), 64'h3);
        check("t4a_fill", 64'(fill), 64'd1);
        push_pair(24'h000007, 24'h000008);
        boundary("t4b");
        check("t4b_l", 64'(lout), 64'h5);
        check("t4b_r", 64'(rout), 64'h6);

        // Fill to full; an extra valid is dropped.
        push_pair(24'h000009, 24'h00000A);
        push_pair(24'h00000B, 24'h00000C);
        push_pair(24'h00000D, 24'h00000E);
        check("t2_fill", 64'(fill), 64'd4);
        check("t2_ready", 64'(ready), 64'd0);
        push_pair(24'h000099, 24'h000099);
        check("t2_fill_hold", 64'(fill), 64'd4);
        boundary("t2");
        check("t2_l", 64'(lout), 64'h7);
        check("t2_ready_back", 64'(ready), 64'd1);
        boundary("t2b");
        check("t2b_l", 64'(lout), 64'h9);
        check("t2b_fill", 64'(fill), 64'd2);

        // Push lands in the very cycle the boundary pops.
        lrck = 1'b1;
        repeat (2) @(negedge clk);
        lrck = 1'b0;
        repeat (2) @(negedge clk);
        valid = 1'b1; lsample = 24'h00000F; rsample = 24'h000010;
        @(negedge clk);
        valid = 1'b0;
        check("t5_tick", 64'(tick), 64'd1);
        check("t5_fill", 64'(fill), 64'd2);
        check("t5_l", 64'(lout), 64'hB);
        check("t5_r", 64'(rout), 64'hC);

        // Reset mid-frame, then a rising LRCK must not tick.
        push_pair(24'h000011, 24'h000012);
        check("t6_pre_fill", 64'(fill), 64'd3);
        rst = 1'b1;
        #1;
        check("t6_fill", 64'(fill), 64'd0);
        check("t6_ready", 64'(ready), 64'd1);
        check("t6_lout", 64'(lout), 64'd0);
        check("t6_rout", 64'(rout), 64'd0);
        check("t6_ucnt", 64'(ucnt), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lrck = 1'b1;
        ticks = 0;
        repeat (8) begin
            @(negedge clk);
            if (tick) ticks++;
        end
        check("t6_no_tick", 64'(ticks), 64'd0);

        // Randomized traffic with varying frame lengths and producer rates.
        half = 4;
        pct = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) pct = (c / 500 % 4 == 0) ? 10 : (c / 500 % 4 == 1) ? 35 :
                                    (c / 500 % 4 == 2) ? 70 : 95;
            if (c == 2000) rst = 1'b1;
            if (c == 2003) rst = 1'b0;
            half--;
            if (half <= 0) begin
                lrck = ~lrck;
                half = int'($urandom_range(1, 12));
            end
            valid   = ($urandom_range(0, 99) < pct);
            lsample = W'($urandom);
            rsample = W'($urandom);
            @(negedge clk);
        end
        valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
